// File: rtl/noc_pkg.sv
// noc_pkg: shared packet field layout, widths, FSM states and request packet builder.
package noc_pkg;
  localparam int REGID_W = 6;
  localparam int PORT_W = 2;
  localparam int VALID_B = 0;
  localparam int DEST_LSB = 1;
  localparam int SRC_LSB = 3;
  localparam int REGID_LSB = 5;
  localparam int RSP_REGID_LSB = 3;
  localparam int RDATA_LSB = 9;
  typedef enum logic {ISSUE, RETRY} state_t;
  function automatic logic [11:0] mk_req(input logic [REGID_W-1:0] r, input logic [PORT_W-1:0] src,
                                         input logic [PORT_W-1:0] dst);
    logic [11:0] p;
    p = '0;
    p[VALID_B] = 1'b1;
    p[DEST_LSB +: PORT_W] = dst;
    p[SRC_LSB +: PORT_W] = src;
    p[REGID_LSB +: REGID_W] = r;
    return p;
  endfunction
endpackage

// File: rtl/noc_requester_if.sv
// noc_requester_if: local request/reply side plus requestor/responder NoC links of noc_requester.
interface noc_requester_if #(parameter int DATA_W = 16, parameter int MAX_OUT = 8);
  import noc_pkg::*;
  logic [PORT_W-1:0] id;
  logic req_valid, req_ready, full, almost_full, write, resp_valid, timeout, err_stray;
  logic [REGID_W-1:0] req_reg_id, resp_reg_id;
  logic [PORT_W-1:0] req_dest;
  logic [11:0] dataOut;
  logic [DATA_W+8:0] dataIn;
  logic [DATA_W-1:0] resp_data;
  logic [$clog2(MAX_OUT+1)-1:0] outstanding;
  modport slave (input id, req_valid, req_reg_id, req_dest, full, almost_full, dataIn,
                 output req_ready, dataOut, write, resp_valid, resp_reg_id, resp_data, timeout, err_stray, outstanding);
  modport master (output id, req_valid, req_reg_id, req_dest, full, almost_full, dataIn,
                  input req_ready, dataOut, write, resp_valid, resp_reg_id, resp_data, timeout, err_stray, outstanding);
endinterface

// File: rtl/noc_req_scoreboard.sv
// noc_req_scoreboard: per-reg_id pending bits, destination table and outstanding count.
module noc_req_scoreboard
  import noc_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_en,
  input  logic [REGID_W-1:0] set_id,
  input  logic [PORT_W-1:0]  set_dest,
  input  logic               clr_en,
  input  logic [REGID_W-1:0] clr_id,
  input  logic               clr_all,
  input  logic [REGID_W-1:0] look_id,
  output logic [63:0]        pending,
  output logic [PORT_W-1:0]  look_dest,
  output logic [OUT_W-1:0]   outstanding
);
  logic [PORT_W-1:0] dest_q [64];
  logic [63:0] set_m, clr_m;
  assign set_m = {63'd0, set_en} << set_id;
  assign clr_m = clr_all ? '1 : {63'd0, clr_en} << clr_id;
  assign look_dest = dest_q[look_id];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending <= '0;
      outstanding <= '0;
    end else begin
      pending <= (pending & ~clr_m) | set_m;
      outstanding <= clr_all ? OUT_W'(set_en) : outstanding + OUT_W'(set_en) - OUT_W'(clr_en);
    end
  // destination entries are only meaningful while their pending bit is set
  always_ff @(posedge clk)
    if (set_en) dest_q[set_id] <= set_dest;
endmodule

// File: rtl/noc_requester.sv
// noc_requester: issues register-read packets, matches responses, watchdog recovery.
// Define NOC_REQ_RETRY_EN to re-issue pending reads on timeout instead of dropping them.
module noc_requester
  import noc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REQ_W = 12,
  parameter int RESP_W = DATA_W + 9,
  parameter int MAX_OUT = 8,
  parameter int TIMEOUT = 1023,
  parameter int TO_W = 10
) (
  input logic clk,
  input logic reset,
  noc_requester_if.slave bus
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  state_t state, state_n;
  logic hold_v, acc, rv, hit, can_send, send, fire, load, adv, clr_all, unused;
  logic [REQ_W-1:0] hold_q;
  logic [RESP_W-1:0] din;
  logic [TO_W-1:0] wd;
  logic [REGID_W-1:0] idx, rid;
  logic [63:0] pending;
  logic [PORT_W-1:0] idx_dest;
  logic [OUT_W-1:0] outstanding;
  assign din = bus.dataIn;
  assign rv = din[VALID_B];
  assign rid = din[RSP_REGID_LSB +: REGID_W];
  assign hit = rv & pending[rid];
  assign bus.req_ready = ~reset & state == ISSUE & ~hold_v & (outstanding < OUT_W'(MAX_OUT)) & ~pending[bus.req_reg_id];
  assign acc = bus.req_valid & bus.req_ready;
  assign can_send = bus.write ? ~bus.almost_full : ~bus.full;
  assign fire = state == ISSUE & outstanding != '0 & ~hit & wd == TO_W'(TIMEOUT);
  assign bus.outstanding = outstanding;
  assign unused = ^{din[DEST_LSB +: PORT_W], idx_dest};
`ifdef NOC_REQ_RETRY_EN
  assign load = state == RETRY & pending[idx] & ~hold_v;
  assign adv = state == RETRY & (~pending[idx] | ~hold_v);
  assign send = hold_v & can_send;
  assign clr_all = 1'b0;
`else
  assign load = 1'b0;
  assign adv = 1'b0;
  assign send = hold_v & can_send & ~fire;
  assign clr_all = fire;
`endif
  always_comb begin
    state_n = state;
`ifdef NOC_REQ_RETRY_EN
    state_n = fire ? RETRY : (adv && idx == '1) ? ISSUE : state;
`endif
  end
  noc_req_scoreboard #(.OUT_W(OUT_W)) u_sb (
    .clk(clk), .reset(reset),
    .set_en(acc), .set_id(bus.req_reg_id), .set_dest(bus.req_dest),
    .clr_en(hit), .clr_id(rid), .clr_all(clr_all),
    .look_id(idx), .pending(pending), .look_dest(idx_dest), .outstanding(outstanding)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ISSUE;
      hold_v <= 1'b0;
      hold_q <= '0;
      wd <= '0;
      idx <= '0;
      bus.write <= 1'b0;
      bus.dataOut <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_reg_id <= '0;
      bus.resp_data <= '0;
      bus.err_stray <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      state <= state_n;
      hold_v <= acc | load | (hold_v & ~send & ~clr_all);
      if (acc | load) hold_q <= acc ? mk_req(bus.req_reg_id, bus.id, bus.req_dest) : mk_req(idx, bus.id, idx_dest);
      bus.write <= send;
      if (send) bus.dataOut <= hold_q;
      wd <= (outstanding == '0 || hit || fire || state == RETRY) ? '0 : wd + TO_W'(1);
      if (adv) idx <= idx + REGID_W'(1);
      bus.resp_valid <= hit;
      if (hit) bus.resp_reg_id <= rid;
      if (hit) bus.resp_data <= din[RDATA_LSB +: DATA_W];
      bus.err_stray <= rv & ~pending[rid];
      bus.timeout <= fire;
    end
endmodule

// File: tb/tb_noc_requester.sv
// tb_noc_requester: randomized and directed checks of noc_requester against a scoreboard model.
module tb_noc_requester;
  import noc_pkg::*;
  localparam int TIMEOUT = 1023;
  localparam int MY_ID = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  bit pend [64];
  int cnt = 0;
  logic [11:0] q [$];
  bit last_write = 1'b0;
  always #5 clk = ~clk;
  noc_requester_if bus();
  noc_requester dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_pkt(input int r, input int p, input int d);
    return 12'(1 + 2 * d + 8 * p + 32 * r);
  endfunction

  function automatic logic [24:0] rsp(input int r, input logic [15:0] data);
    return {data, 6'(r), 2'd0, 1'b1};
  endfunction

  function automatic bit exp_ready();
    return !reset && !pend[bus.req_reg_id] && cnt < 8 && q.size() == 0;
  endfunction

  task automatic drive(input bit v, input int r, input int d, input bit f, input bit af, input logic [24:0] din);
    bus.req_valid = v;
    bus.req_reg_id = 6'(r);
    bus.req_dest = 2'(d);
    bus.full = f;
    bus.almost_full = af;
    bus.dataIn = din;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0);
  endtask

  task automatic clear_model();
    foreach (pend[i]) pend[i] = 1'b0;
    cnt = 0;
    q.delete();
    last_write = 1'b0;
  endtask

  // one clock: inputs were driven at the preceding negedge
  task automatic cycle();
    bit acc, hit, stray, exp_w;
    logic [11:0] exp_d;
    int r, d, rid;
    logic [15:0] rdata;
    exp_d = '0;
    #1;
    check("req_ready", bus.req_ready, exp_ready());
    acc = bus.req_valid && exp_ready();
    r = bus.req_reg_id;
    d = bus.req_dest;
    rid = bus.dataIn[8:3];
    rdata = bus.dataIn[24:9];
    hit = bus.dataIn[0] && pend[rid];
    stray = bus.dataIn[0] && !pend[rid];
    exp_w = q.size() > 0 && (last_write ? !bus.almost_full : !bus.full);
    @(posedge clk);
    if (exp_w) exp_d = q.pop_front();
    if (acc) begin
      pend[r] = 1'b1;
      cnt++;
      q.push_back(exp_pkt(r, MY_ID, d));
    end
    if (hit) begin
      pend[rid] = 1'b0;
      cnt--;
    end
    last_write = exp_w;
    @(negedge clk);
    check("write", bus.write, exp_w);
    if (exp_w) check("dataOut", bus.dataOut, exp_d);
    check("resp_valid", bus.resp_valid, hit);
    if (hit) check("resp_reg_id", bus.resp_reg_id, rid);
    if (hit) check("resp_data", bus.resp_data, rdata);
    check("err_stray", bus.err_stray, stray);
    check("outstanding", bus.outstanding, cnt);
    check("timeout", bus.timeout, 0);
  endtask

  task automatic drain();
    for (int g = 0; g < 300 && (cnt > 0 || q.size() > 0); g++) begin
      int p;
      p = -1;
      foreach (pend[i]) if (pend[i] && p < 0) p = i;
      drive(0, 0, 0, 0, 0, p >= 0 ? rsp(p, 16'($urandom)) : 25'd0);
      cycle();
    end
    idle();
    cycle();
  endtask

  task automatic random_phase();
    for (int c = 0; c < 400; c++) begin
      int ids[$];
      int k;
      logic [24:0] din;
      ids.delete();
      foreach (pend[i]) if (pend[i]) ids.push_back(i);
      k = $urandom_range(0, 9);
      din = 25'($urandom) & ~25'd1;
      if (k < 4 && ids.size() > 0) din = rsp(ids[$urandom_range(0, ids.size() - 1)], 16'($urandom));
      else if (k == 4) din = rsp($urandom_range(0, 15), 16'($urandom));
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 3),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, din);
      cycle();
    end
    drain();
  endtask

  task automatic timeout_test();
    int n;
    bit seen;
`ifdef NOC_REQ_RETRY_EN
    logic [11:0] got [$];
`endif
    n = 0;
    seen = 1'b0;
    drain();
    drive(1, 3, 1, 0, 0, '0); cycle();
    idle(); cycle();
    drive(1, 40, 3, 0, 0, '0); cycle();
    idle(); cycle();
    for (int i = 0; i < TIMEOUT + 40 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = bus.timeout;
    end
    check("timeout_seen", seen, 1);
    check("timeout_window", n >= TIMEOUT - 10 && n <= TIMEOUT + 10, 1);
`ifdef NOC_REQ_RETRY_EN
    check("retry_outstanding", bus.outstanding, 2);
    #1 check("retry_ready", bus.req_ready, 0);
    for (int i = 0; i < 100; i++) begin
      drive(0, 0, 0, $urandom_range(0, 3) == 0, 0, '0);
      @(negedge clk);
      if (bus.write) got.push_back(bus.dataOut);
    end
    check("retry_count", got.size(), 2);
    check("retry_first", got.size() > 0 ? got[0] : 12'h0, exp_pkt(3, MY_ID, 1));
    check("retry_second", got.size() > 1 ? got[1] : 12'h0, exp_pkt(40, MY_ID, 3));
    last_write = 1'b0;
    drive(1, 50, 2, 0, 0, '0); cycle();
    idle(); cycle();
    drain();
`else
    check("timeout_outstanding", bus.outstanding, 0);
    clear_model();
    drive(0, 0, 0, 0, 0, rsp(3, 16'h1234)); cycle();
    check("late_stray", bus.err_stray, 1);
    idle(); cycle();
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.id = 2'(MY_ID);
    idle();
    @(negedge clk);
    check("rst_write", bus.write, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_dataOut", bus.dataOut, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 5, 2, 0, 0, '0); cycle();
    idle(); cycle();
    check("first_pkt", bus.dataOut, 12'h0AD);
    drive(1, 7, 1, 1, 0, '0); cycle();
    repeat (3) begin
      drive(0, 0, 0, 1, 0, '0); cycle();
      check("held_write", bus.write, 0);
    end
    drive(1, 9, 3, 0, 1, '0); cycle();
    drive(1, 9, 3, 0, 1, '0); cycle();
    drive(0, 0, 0, 0, 1, '0); cycle();
    cycle();
    drive(0, 0, 0, 0, 0, {16'hBEEF, 6'd5, 2'd1, 1'b1}); cycle();
    check("beef_data", bus.resp_data, 16'hBEEF);
    check("beef_reg", bus.resp_reg_id, 5);
    cycle();
    check("repeat_stray", bus.err_stray, 1);
    drain();
    for (int i = 0; i < 8; i++) begin
      drive(1, 20 + i, i % 4, 0, 0, '0); cycle();
      idle(); cycle();
    end
    drive(1, 30, 0, 0, 0, '0); cycle();
    #1 check("ready_at_max", bus.req_ready, 0);
    drive(1, 21, 0, 0, 0, rsp(20, 16'h0101)); cycle();
    #1 check("dup_stall", bus.req_ready, 0);
    drive(1, 21, 0, 0, 0, rsp(21, 16'h0202)); cycle();
    drive(1, 21, 0, 0, 0, '0); cycle();
    check("dup_accepted", bus.outstanding, 7);
    drain();
    random_phase();
    timeout_test();
    drain();
    for (int i = 10; i < 13; i++) begin
      drive(1, i, 2, 0, 0, '0); cycle();
      idle(); cycle();
    end
    drive(1, 13, 0, 1, 0, '0); cycle();
    drive(0, 0, 0, 1, 0, '0); cycle();
    #2 reset = 1'b1;
    #1;
    check("arst_outstanding", bus.outstanding, 0);
    check("arst_write", bus.write, 0);
    check("arst_ready", bus.req_ready, 0);
    check("arst_dataOut", bus.dataOut, 0);
    check("arst_resp_reg", bus.resp_reg_id, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    drive(0, 0, 0, 0, 0, rsp(10, 16'h5555)); cycle();
    check("post_reset_stray", bus.err_stray, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
